// File: rtl/mips_pkg.sv
// mips_pkg: shared shadow-entry type, register-address sizing and forwarding constants for pipe_hazard_ctrl
package mips_pkg;
  localparam int REG_AW_DEFAULT = 5;
  // shadow entries store addresses at the widest supported width; narrower ids zero-extend
  localparam int REG_AW_MAX = 8;
  localparam logic [2:0] FWD_RF = 3'd0;
  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] rs;
    logic [REG_AW_MAX-1:0] rt;
    logic                  uses_rs;
    logic                  uses_rt;
    logic [REG_AW_MAX-1:0] dest;
    logic                  reg_write;
    logic                  mem_read;
  } shadow_t;
  function automatic logic src_match(input shadow_t e, input logic [REG_AW_MAX-1:0] src, input logic uses);
    return e.valid & e.reg_write & (e.dest != '0) & (e.dest == src) & uses;
  endfunction
endpackage

// File: rtl/pipe_shadow_stage.sv
// pipe_shadow_stage: one shadow-entry register with hold (freeze) and bubble (kill) controls
module pipe_shadow_stage
  import mips_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    hold_i,
  input  logic    bubble_i,
  input  shadow_t entry_i,
  output shadow_t entry_o
);
  shadow_t entry_q, entry_d;
  always_comb entry_d = hold_i ? entry_q : (bubble_i ? '0 : entry_i);
  always_ff @(posedge clk or posedge rst)
    if (rst) entry_q <= '0;
    else entry_q <= entry_d;
  assign entry_o = entry_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use/RAW stall, branch flush and forwarding-select control; FWD_UNIT_EN enables forwarding
module pipe_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int NSTG   = 3,
  parameter int LD_STG = 2,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              br_taken,
  input  logic              mem_ready,
  output logic              stall_if_id,
  output logic              flush,
  output logic [2:0]        fwd_rs_sel,
  output logic [2:0]        fwd_rt_sel,
  output logic [NSTG-1:0]   stage_valid,
  output logic [15:0]       stall_cnt
);
  shadow_t id_e;
  shadow_t st_q [1:NSTG];
  logic hazard;
  logic [15:0] cnt_q, cnt_d;
  always_comb begin
    id_e = '0;
    id_e.valid = 1'b1;
    id_e.rs = REG_AW_MAX'(id_rs);
    id_e.rt = REG_AW_MAX'(id_rt);
    id_e.uses_rs = id_uses_rs;
    id_e.uses_rt = id_uses_rt;
    id_e.dest = REG_AW_MAX'(id_rd);
    id_e.reg_write = id_reg_write;
    id_e.mem_read = id_mem_read;
  end
  always_comb begin
    hazard = 1'b0;
    for (int k = 1; k < NSTG; k++)
`ifdef FWD_UNIT_EN
      if (k < LD_STG && st_q[k].mem_read &&
          (src_match(st_q[k], id_e.rs, id_uses_rs) || src_match(st_q[k], id_e.rt, id_uses_rt))) hazard = 1'b1;
`else
      if (src_match(st_q[k], id_e.rs, id_uses_rs) || src_match(st_q[k], id_e.rt, id_uses_rt)) hazard = 1'b1;
`endif
  end
  assign flush = br_taken & st_q[1].valid & mem_ready;
  // reset abandons any freeze, so the stall request is masked while rst is high
  assign stall_if_id = !rst & !flush & (!mem_ready | (id_valid & hazard));
  for (genvar k = 1; k <= NSTG; k++) begin : g_stg
    if (k == 1) begin : g_head
      pipe_shadow_stage u_stage (
        .clk      (clk),
        .rst      (rst),
        .hold_i   (!mem_ready),
        .bubble_i (!(id_valid & !stall_if_id & !flush)),
        .entry_i  (id_e),
        .entry_o  (st_q[k])
      );
    end else begin : g_tail
      pipe_shadow_stage u_stage (
        .clk      (clk),
        .rst      (rst),
        .hold_i   (!mem_ready && k <= LD_STG),
        .bubble_i (!mem_ready && k == LD_STG + 1),
        .entry_i  (st_q[k-1]),
        .entry_o  (st_q[k])
      );
    end
    assign stage_valid[k-1] = st_q[k].valid;
  end
  always_comb begin
    fwd_rs_sel = FWD_RF;
    fwd_rt_sel = FWD_RF;
`ifdef FWD_UNIT_EN
    for (int k = NSTG; k >= 2; k--) begin
      if ((k > LD_STG || !st_q[k].mem_read) && src_match(st_q[k], st_q[1].rs, st_q[1].uses_rs)) fwd_rs_sel = 3'(k);
      if ((k > LD_STG || !st_q[k].mem_read) && src_match(st_q[k], st_q[1].rt, st_q[1].uses_rt)) fwd_rt_sel = 3'(k);
    end
`endif
  end
  assign cnt_d = (stall_if_id && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table-driven directed bench for pipe_hazard_ctrl, expectations switch on FWD_UNIT_EN
module tb_pipe_hazard_ctrl;
  typedef struct packed {
    logic v, rw, mr, urs, urt;
    logic [4:0] rs, rt, rd;
  } id_t;
  typedef struct packed {
    id_t id;
    logic st;
    logic [2:0] frs, frt, sv;
    logic [15:0] cnt;
  } vec_t;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam id_t NOP = '0;
  logic clk = 1'b0, rst;
  logic id_valid, id_reg_write, id_mem_read, id_uses_rs, id_uses_rt;
  logic [4:0] id_rs, id_rt, id_rd;
  logic br_taken, mem_ready;
  logic stall_if_id, flush;
  logic [2:0] fwd_rs_sel, fwd_rt_sel, stage_valid;
  logic [15:0] stall_cnt;
  int n_chk = 0, n_fail = 0;
  vec_t tbl[$];
  id_t lw2, add3, add5, sub6, or8, a10, b10, c11, lw0, add12, y8, x7, z9;
  always #5 clk = ~clk;
  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .br_taken(br_taken), .mem_ready(mem_ready), .stall_if_id(stall_if_id), .flush(flush),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .stage_valid(stage_valid), .stall_cnt(stall_cnt)
  );
  function automatic id_t mk(input logic rw, mr, urs, urt, input logic [4:0] rs, rt, rd);
    return '{H, rw, mr, urs, urt, rs, rt, rd};
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic expect_o(input string tag, input logic st, fl, input logic [2:0] frs, frt, sv, input logic [15:0] cnt);
    chk({tag, " stall_if_id"}, int'(stall_if_id), int'(st));
    chk({tag, " flush"}, int'(flush), int'(fl));
    chk({tag, " fwd_rs_sel"}, int'(fwd_rs_sel), int'(frs));
    chk({tag, " fwd_rt_sel"}, int'(fwd_rt_sel), int'(frt));
    chk({tag, " stage_valid"}, int'(stage_valid), int'(sv));
    chk({tag, " stall_cnt"}, int'(stall_cnt), int'(cnt));
  endtask
  task automatic drive(input id_t i, input logic br, input logic rdy);
    id_valid = i.v; id_reg_write = i.rw; id_mem_read = i.mr; id_uses_rs = i.urs; id_uses_rt = i.urt;
    id_rs = i.rs; id_rt = i.rt; id_rd = i.rd; br_taken = br; mem_ready = rdy;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_dut();
    rst = 1'b1;
    drive(NOP, L, H);
    step();
    rst = 1'b0;
  endtask
  task automatic push(input id_t id, input logic st, input logic [2:0] frs, frt, sv, input logic [15:0] cnt);
    tbl.push_back('{id, st, frs, frt, sv, cnt});
  endtask
  initial begin
    lw2 = mk(H, H, H, L, 5'd1, 5'd0, 5'd2);
    add3 = mk(H, L, H, H, 5'd2, 5'd4, 5'd3);
    add5 = mk(H, L, H, H, 5'd1, 5'd1, 5'd5);
    sub6 = mk(H, L, H, H, 5'd5, 5'd0, 5'd6);
    or8 = mk(H, L, H, H, 5'd9, 5'd6, 5'd8);
    a10 = mk(H, L, L, L, 5'd0, 5'd0, 5'd10);
    b10 = mk(H, L, L, L, 5'd0, 5'd0, 5'd10);
    c11 = mk(H, L, H, H, 5'd10, 5'd10, 5'd11);
    lw0 = mk(H, H, H, L, 5'd1, 5'd0, 5'd0);
    add12 = mk(H, L, H, H, 5'd0, 5'd0, 5'd12);
    y8 = mk(H, L, L, L, 5'd0, 5'd0, 5'd8);
    x7 = mk(H, L, L, L, 5'd0, 5'd0, 5'd7);
    z9 = mk(H, L, L, L, 5'd0, 5'd0, 5'd9);
`ifdef FWD_UNIT_EN
    push(NOP,   L, 3'd0, 3'd0, 3'b000, 16'd0);
    push(lw2,   L, 3'd0, 3'd0, 3'b000, 16'd0);
    push(add3,  H, 3'd0, 3'd0, 3'b001, 16'd0);
    push(add3,  L, 3'd0, 3'd0, 3'b010, 16'd1);
    push(add5,  L, 3'd3, 3'd0, 3'b101, 16'd1);
    push(sub6,  L, 3'd0, 3'd0, 3'b011, 16'd1);
    push(or8,   L, 3'd2, 3'd0, 3'b111, 16'd1);
    push(a10,   L, 3'd0, 3'd2, 3'b111, 16'd1);
    push(b10,   L, 3'd0, 3'd0, 3'b111, 16'd1);
    push(c11,   L, 3'd0, 3'd0, 3'b111, 16'd1);
    push(NOP,   L, 3'd2, 3'd2, 3'b111, 16'd1);
    push(lw0,   L, 3'd0, 3'd0, 3'b110, 16'd1);
    push(add12, L, 3'd0, 3'd0, 3'b101, 16'd1);
    push(NOP,   L, 3'd0, 3'd0, 3'b011, 16'd1);
`else
    push(NOP,   L, 3'd0, 3'd0, 3'b000, 16'd0);
    push(lw2,   L, 3'd0, 3'd0, 3'b000, 16'd0);
    push(add3,  H, 3'd0, 3'd0, 3'b001, 16'd0);
    push(add3,  H, 3'd0, 3'd0, 3'b010, 16'd1);
    push(add3,  L, 3'd0, 3'd0, 3'b100, 16'd2);
    push(add5,  L, 3'd0, 3'd0, 3'b001, 16'd2);
    push(sub6,  H, 3'd0, 3'd0, 3'b011, 16'd2);
    push(sub6,  H, 3'd0, 3'd0, 3'b110, 16'd3);
    push(sub6,  L, 3'd0, 3'd0, 3'b100, 16'd4);
    push(lw0,   L, 3'd0, 3'd0, 3'b001, 16'd4);
    push(add12, L, 3'd0, 3'd0, 3'b011, 16'd4);
    push(NOP,   L, 3'd0, 3'd0, 3'b111, 16'd4);
`endif
    rst = 1'b1;
    drive(NOP, L, H);
    #2;
    expect_o("reset", L, L, 3'd0, 3'd0, 3'b000, 16'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].id, L, H);
      @(negedge clk);
      expect_o($sformatf("row%0d", i), tbl[i].st, L, tbl[i].frs, tbl[i].frt, tbl[i].sv, tbl[i].cnt);
      step();
    end
    // freeze with a load in stage 2, then a branch held across the freeze
    reset_dut();
    drive(y8, L, H); step();
    drive(lw2, L, H); step();
    drive(x7, L, H); step();
    drive(NOP, L, L);
    @(negedge clk); expect_o("frz1", H, L, 3'd0, 3'd0, 3'b111, 16'd0); step();
    @(negedge clk); expect_o("frz2", H, L, 3'd0, 3'd0, 3'b011, 16'd1); step();
    drive(NOP, H, L);
    @(negedge clk); expect_o("frz3_br", H, L, 3'd0, 3'd0, 3'b011, 16'd2); step();
    drive(z9, H, H);
    @(negedge clk); expect_o("frz_release", L, H, 3'd0, 3'd0, 3'b011, 16'd3); step();
    drive(NOP, L, L);
    @(negedge clk); expect_o("post_flush", H, L, 3'd0, 3'd0, 3'b110, 16'd3); step();
    expect_o("refrz", H, L, 3'd0, 3'd0, 3'b010, 16'd4);
    rst = 1'b1;
    #2;
    expect_o("async_rst", L, L, 3'd0, 3'd0, 3'b000, 16'd0);
    step();
    rst = 1'b0;
    drive(x7, L, H);
    @(negedge clk); expect_o("post_rst", L, L, 3'd0, 3'd0, 3'b000, 16'd0); step();
    drive(NOP, L, H);
    @(negedge clk); expect_o("first_adv", L, L, 3'd0, 3'd0, 3'b001, 16'd0);
    step();
    // branch overrides a pending load-use stall
    reset_dut();
    drive(lw2, L, H); step();
    drive(add3, L, H);
    @(negedge clk); expect_o("ldu_nobr", H, L, 3'd0, 3'd0, 3'b001, 16'd0);
    br_taken = 1'b1;
    #1;
    expect_o("br_flush", L, H, 3'd0, 3'd0, 3'b001, 16'd0);
    step();
    drive(NOP, L, H);
    @(negedge clk); expect_o("br_after", L, L, 3'd0, 3'd0, 3'b010, 16'd0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
